imf_residue_extractor: RTL and testbench

//  Consumer end of the start/follow_start sifting handshake. Buffers the raw frame

---
 rtl/imf_residue_extractor.sv | 177 +++++++++++++++++
 tb/tb_imf_residue_extractor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imf_residue_extractor.sv
// Buffers raw EMD frames and subtracts the matching IMF frame to produce the residue
// for the next sifting stage, with start->follow_start latency and error tracking.
module imf_residue_extractor #(
   parameter int FRAME_LEN = 64,
   parameter int DEPTH     = 256,
   parameter int AW        = 8
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               start,
   input  logic signed [15:0] Xin,
   input  logic               follow_start,
   input  logic signed [15:0] Cout,
   output logic               res_start,
   output logic signed [15:0] Rout,
   output logic               res_valid,
   output logic [15:0]        lat_cycles,
   output logic               err_overrun,
   output logic               err_orphan
);
   localparam int CW = $clog2(FRAME_LEN + 1);

   typedef enum logic {W_IDLE, W_CAP}  wstate_t;
   typedef enum logic {R_IDLE, R_EMIT} rstate_t;

   wstate_t            w_state_q, w_state_d;
   rstate_t            r_state_q, r_state_d;
   logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]      wcnt_q, wcnt_d, rcnt_q, rcnt_d;
   logic [AW:0]        occ_q, occ_d;
   logic [15:0]        pend_q, pend_d;
   logic               lat_run_q, lat_run_d;
   logic [15:0]        lat_cnt_q, lat_cnt_d, lat_q, lat_d;
   logic signed [15:0] rout_q, rout_d;
   logic               rvld_q, rvld_d, rstart_q, rstart_d;
   logic               ovr_q, ovr_d, orph_q, orph_d;
   logic               wr_act, wr_ok, rd_act, open_frm, accept;
   logic signed [16:0] diff;
   logic signed [15:0] mem_q [DEPTH];

   // Overflow of the 17-bit difference shows up as disagreement of the top two bits.
   function automatic logic signed [15:0] sat17(input logic signed [16:0] d);
      if (d[16] != d[15]) return d[16] ? 16'sh8000 : 16'sh7FFF;
      return $signed(d[15:0]);
   endfunction

   always_comb begin
      w_state_d = w_state_q;
      r_state_d = r_state_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      wcnt_d    = wcnt_q;
      rcnt_d    = rcnt_q;
      pend_d    = pend_q;
      lat_run_d = lat_run_q;
      lat_cnt_d = lat_cnt_q;
      lat_d     = lat_q;
      ovr_d     = ovr_q;
      orph_d    = orph_q;
      rout_d    = 16'sd0;
      rvld_d    = 1'b0;
      rstart_d  = 1'b0;
      wr_act    = 1'b0;
      rd_act    = 1'b0;
      open_frm  = 1'b0;
      accept    = 1'b0;
      diff      = {mem_q[rptr_q][15], mem_q[rptr_q]} - {Cout[15], Cout};

      case (w_state_q)
         W_IDLE: if (start) begin
            wr_act   = 1'b1;
            open_frm = 1'b1;
         end
         default: wr_act = 1'b1;
      endcase
      if (wr_act) begin
         if (wcnt_q == CW'(FRAME_LEN - 1)) begin
            w_state_d = W_IDLE;
            wcnt_d    = '0;
         end else begin
            w_state_d = W_CAP;
            wcnt_d    = wcnt_q + 1'b1;
         end
      end

      case (r_state_q)
         R_IDLE: if (follow_start) begin
            if (pend_q != 16'd0) begin
               rd_act = 1'b1;
               accept = 1'b1;
            end else begin
               orph_d = 1'b1;
            end
         end
         default: rd_act = 1'b1;
      endcase
      if (rd_act) begin
         rptr_d   = rptr_q + 1'b1;
         rvld_d   = 1'b1;
         rstart_d = accept;
         rout_d   = sat17(diff);
         if (rcnt_q == CW'(FRAME_LEN - 1)) begin
            r_state_d = R_IDLE;
            rcnt_d    = '0;
         end else begin
            r_state_d = R_EMIT;
            rcnt_d    = rcnt_q + 1'b1;
         end
      end

      // A full buffer still accepts a write when the same cycle frees an entry.
      wr_ok = wr_act && ((occ_q != (AW+1)'(DEPTH)) || rd_act);
      if (wr_act && !wr_ok) ovr_d = 1'b1;
      if (wr_ok) wptr_d = wptr_q + 1'b1;
      occ_d  = occ_q + (AW+1)'(wr_ok) - (AW+1)'(rd_act);
      pend_d = pend_q + 16'(open_frm) - 16'(accept);

      if (lat_run_q && lat_cnt_q != 16'hFFFF) lat_cnt_d = lat_cnt_q + 16'd1;
      if (accept && lat_run_q) begin
         lat_d     = lat_cnt_q;
         lat_run_d = 1'b0;
      end
      if (open_frm && pend_q == 16'd0) begin
         lat_run_d = 1'b1;
         lat_cnt_d = 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         wptr_q    <= '0;
         rptr_q    <= '0;
         wcnt_q    <= '0;
         rcnt_q    <= '0;
         occ_q     <= '0;
         pend_q    <= '0;
         lat_run_q <= 1'b0;
         lat_cnt_q <= '0;
         lat_q     <= '0;
         rout_q    <= '0;
         rvld_q    <= 1'b0;
         rstart_q  <= 1'b0;
         ovr_q     <= 1'b0;
         orph_q    <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         wcnt_q    <= wcnt_d;
         rcnt_q    <= rcnt_d;
         occ_q     <= occ_d;
         pend_q    <= pend_d;
         lat_run_q <= lat_run_d;
         lat_cnt_q <= lat_cnt_d;
         lat_q     <= lat_d;
         rout_q    <= rout_d;
         rvld_q    <= rvld_d;
         rstart_q  <= rstart_d;
         ovr_q     <= ovr_d;
         orph_q    <= orph_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (wr_ok) mem_q[wptr_q] <= Xin;
   end

   assign Rout        = rout_q;
   assign res_valid   = rvld_q;
   assign res_start   = rstart_q;
   assign lat_cycles  = lat_q;
   assign err_overrun = ovr_q;
   assign err_orphan  = orph_q;
endmodule

// File: tb/tb_imf_residue_extractor.sv
// Bench for imf_residue_extractor: cycle-table stimulus compared against a queue-based
// frame model, plus a small-buffer instance for the overrun case.
module tb_imf_residue_extractor;
   localparam int FL = 4;
   localparam int NC = 64;

   logic               CLK = 1'b0, RST_N = 1'b0;
   logic               start = 1'b0, follow_start = 1'b0;
   logic signed [15:0] Xin = '0, Cout = '0;
   logic               res_start, res_valid, err_overrun, err_orphan;
   logic signed [15:0] Rout;
   logic [15:0]        lat_cycles;

   logic               s_start = 1'b0, s_fs = 1'b0;
   logic signed [15:0] s_xin = '0, s_cout = '0;
   logic               s_rs, s_rv, s_ovr, s_orph;
   logic signed [15:0] s_rout;
   logic [15:0]        s_lat;

   int          n_pass = 0, n_total = 0;
   bit          st [NC], fs [NC];
   int          xi [NC], co [NC];
   logic [17:0] obs [NC], exp_tr [NC];
   int          exp_lat;
   bit          exp_orph;

   imf_residue_extractor #(.FRAME_LEN(FL), .DEPTH(256), .AW(8)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .Xin(Xin), .follow_start(follow_start),
      .Cout(Cout), .res_start(res_start), .Rout(Rout), .res_valid(res_valid),
      .lat_cycles(lat_cycles), .err_overrun(err_overrun), .err_orphan(err_orphan));

   imf_residue_extractor #(.FRAME_LEN(FL), .DEPTH(8), .AW(3)) dut_small (
      .CLK(CLK), .RST_N(RST_N), .start(s_start), .Xin(s_xin), .follow_start(s_fs),
      .Cout(s_cout), .res_start(s_rs), .Rout(s_rout), .res_valid(s_rv),
      .lat_cycles(s_lat), .err_overrun(s_ovr), .err_orphan(s_orph));

   always #5 CLK = ~CLK;

   function automatic int sat(int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Reference: raw frames queue up in arrival order; each accepted follow_start
   // consumes one whole frame, residue registered at the edge ending that cycle.
   function automatic void model(int n);
      int raw[$];
      int pend = 0, emit = 0, cap = 0, t0 = -1, pb;
      exp_lat = 0; exp_orph = 0;
      for (int k = 0; k < n; k++) begin
         pb = pend;
         exp_tr[k] = '0;
         if (emit > 0) begin
            exp_tr[k] = {1'b1, 1'b0, 16'(sat(raw.pop_front() - co[k]))};
            emit--;
         end else if (fs[k]) begin
            if (pb > 0) begin
               exp_tr[k] = {1'b1, 1'b1, 16'(sat(raw.pop_front() - co[k]))};
               emit = FL - 1;
               pend--;
               if (t0 >= 0) begin exp_lat = k - t0; t0 = -1; end
            end else exp_orph = 1;
         end
         if (cap > 0) begin
            raw.push_back(xi[k]);
            cap--;
         end else if (st[k]) begin
            if (pb == 0) t0 = k;
            pend++;
            raw.push_back(xi[k]);
            cap = FL - 1;
         end
      end
   endfunction

   task automatic clear_stim();
      for (int k = 0; k < NC; k++) begin
         st[k] = 0; fs[k] = 0; xi[k] = 0; co[k] = 0;
      end
   endtask

   task automatic apply(input int n);
      for (int k = 0; k < n; k++) begin
         start = st[k]; Xin = 16'(xi[k]); follow_start = fs[k]; Cout = 16'(co[k]);
         @(posedge CLK); #1;
         obs[k] = {res_valid, res_start, Rout};
      end
      start = 0; follow_start = 0; Xin = '0; Cout = '0;
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1 RST_N = 1'b1;
   endtask

   task automatic frame(input int s, input int f, input int x[FL], input int c[FL]);
      st[s] = 1; fs[f] = 1;
      for (int j = 0; j < FL; j++) begin xi[s+j] = x[j]; co[f+j] = c[j]; end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      n_total++;
      if ({res_valid, res_start, Rout, lat_cycles, err_overrun, err_orphan} !== '0)
         $display("FAIL reset_outputs got v%b s%b r%0d l%0d o%b e%b want all 0",
                  res_valid, res_start, Rout, lat_cycles, err_overrun, err_orphan);
      else n_pass++;
      n_total++;
      if ({s_rv, s_rs, s_rout, s_lat, s_ovr, s_orph} !== '0)
         $display("FAIL reset_small got nonzero outputs want all 0");
      else n_pass++;
      RST_N = 1'b1;
   endtask

   task automatic test_basic();
      int rv[FL] = '{90, 180, -330, -40};
      do_reset(); clear_stim();
      frame(0, 5, '{100, 200, -300, 0}, '{10, 20, 30, 40});
      apply(12); model(12);
      for (int k = 0; k < 12; k++) begin
         n_total++;
         if (obs[k] !== exp_tr[k]) $display("FAIL basic_trace cyc%0d got %h want %h", k, obs[k], exp_tr[k]);
         else n_pass++;
      end
      for (int j = 0; j < FL; j++) begin
         n_total++;
         if (obs[5+j][15:0] !== 16'(rv[j]) || obs[5+j][17] !== 1'b1 || obs[5+j][16] !== (j == 0))
            $display("FAIL basic_residue%0d got %h want r=%0d", j, obs[5+j], rv[j]);
         else n_pass++;
      end
      n_total++;
      if (lat_cycles !== 16'd5) $display("FAIL basic_lat got %0d want 5", lat_cycles);
      else n_pass++;
      n_total++;
      if (err_orphan !== 1'b0 || err_overrun !== 1'b0)
         $display("FAIL basic_errs got o%b e%b want 0 0", err_overrun, err_orphan);
      else n_pass++;
   endtask

   task automatic test_saturation();
      int rv[FL] = '{32767, -32768, 32767, -32768};
      do_reset(); clear_stim();
      frame(0, 2, '{32000, -32000, 32767, -32768}, '{-1000, 1000, -1, 1});
      apply(8); model(8);
      for (int j = 0; j < FL; j++) begin
         n_total++;
         if (obs[2+j] !== exp_tr[2+j] || obs[2+j][15:0] !== 16'(rv[j]))
            $display("FAIL sat_residue%0d got %h want r=%0d", j, obs[2+j], rv[j]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int rs_cnt = 0;
      do_reset(); clear_stim();
      frame(0, 10, '{1, -2, 3, -4}, '{5, 6, 7, 8});
      frame(4, 14, '{1000, 2000, -3000, 4000}, '{-7, 0, 9, 32767});
      apply(20); model(20);
      for (int k = 0; k < 20; k++) begin
         rs_cnt += int'(obs[k][16]);
         n_total++;
         if (obs[k] !== exp_tr[k]) $display("FAIL b2b_trace cyc%0d got %h want %h", k, obs[k], exp_tr[k]);
         else n_pass++;
      end
      n_total++;
      if (rs_cnt != 2) $display("FAIL b2b_res_start_count got %0d want 2", rs_cnt);
      else n_pass++;
      n_total++;
      if (lat_cycles !== 16'd10) $display("FAIL b2b_lat got %0d want 10", lat_cycles);
      else n_pass++;
   endtask

   task automatic test_orphan();
      do_reset(); clear_stim();
      fs[0] = 1; co[0] = 123;
      frame(3, 6, '{-50, 60, -70, 80}, '{1, 2, 3, 4});
      apply(12); model(12);
      for (int k = 0; k < 12; k++) begin
         n_total++;
         if (obs[k] !== exp_tr[k]) $display("FAIL orphan_trace cyc%0d got %h want %h", k, obs[k], exp_tr[k]);
         else n_pass++;
      end
      n_total++;
      if (err_orphan !== 1'b1 || exp_orph != 1) $display("FAIL orphan_flag got %b want 1", err_orphan);
      else n_pass++;
      n_total++;
      if (lat_cycles !== 16'(exp_lat)) $display("FAIL orphan_lat got %0d want %0d", lat_cycles, exp_lat);
      else n_pass++;
   endtask

   task automatic test_overrun();
      for (int k = 0; k < 12; k++) begin
         s_start = (k % 4 == 0); s_xin = 16'(k);
         @(posedge CLK); #1;
         if (k == 7 || k == 8 || k == 11) begin
            n_total++;
            if (s_ovr !== (k >= 8)) $display("FAIL overrun_after_write%0d got %b want %b", k + 1, s_ovr, k >= 8);
            else n_pass++;
         end
      end
      s_start = 0; s_xin = '0;
   endtask

   task automatic test_random();
      int s, f, pf, n, nf;
      int x[FL], c[FL];
      for (int rep = 0; rep < 4; rep++) begin
         do_reset(); clear_stim();
         s = 0; pf = -10; nf = 2 + int'($urandom_range(0, 1));
         for (int i = 0; i < nf; i++) begin
            if (i > 0) s = s + 4 + int'($urandom_range(0, 3));
            f = s + 1 + int'($urandom_range(0, 6));
            if (f < pf + 4) f = pf + 4 + int'($urandom_range(0, 2));
            for (int j = 0; j < FL; j++) begin
               x[j] = int'($signed(16'($urandom)));
               c[j] = int'($signed(16'($urandom)));
            end
            frame(s, f, x, c);
            pf = f;
         end
         n = pf + FL + 2;
         apply(n); model(n);
         for (int k = 0; k < n; k++) begin
            n_total++;
            if (obs[k] !== exp_tr[k]) $display("FAIL rand%0d_trace cyc%0d got %h want %h", rep, k, obs[k], exp_tr[k]);
            else n_pass++;
         end
         n_total++;
         if (lat_cycles !== 16'(exp_lat)) $display("FAIL rand%0d_lat got %0d want %0d", rep, lat_cycles, exp_lat);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_emit();
      do_reset(); clear_stim();
      frame(0, 2, '{11, 22, 33, 44}, '{1, 1, 1, 1});
      apply(4);
      n_total++;
      if (obs[3] !== {1'b1, 1'b0, 16'sd21} || lat_cycles !== 16'd2)
         $display("FAIL midreset_pre got %h lat %0d want %h lat 2", obs[3], lat_cycles, {1'b1, 1'b0, 16'sd21});
      else n_pass++;
      #2 RST_N = 1'b0;
      #1;
      n_total++;
      if ({res_valid, res_start, Rout, lat_cycles, err_overrun, err_orphan} !== '0)
         $display("FAIL midreset_async got v%b r%0d l%0d want all 0", res_valid, Rout, lat_cycles);
      else n_pass++;
      @(posedge CLK); #1 RST_N = 1'b1;
      clear_stim();
      frame(1, 3, '{-5, 500, 32767, -1}, '{5, -500, -32768, 1});
      apply(10); model(10);
      for (int k = 0; k < 10; k++) begin
         n_total++;
         if (obs[k] !== exp_tr[k]) $display("FAIL postreset_trace cyc%0d got %h want %h", k, obs[k], exp_tr[k]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_back_to_back();
      test_orphan();
      test_overrun();
      test_random();
      test_reset_mid_emit();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
